sys_array_mac_ctrl: RTL and testbench

Sequencer that time-multiplexes one sys_array_cell as a dot-product engine, computing sum(par[k]*inp[k]) for k = 0..VEC_LEN-1. Per element it loads the weight (param_load), presents input and running accumulator (prop_data), waits the cell latency, then captures out_data as the new accumulator. It compares the final sum against the preset's expected value. It sits between read_data-style preset storage, the debounced start button and the seven_segment_4_digits display.

---
 rtl/sys_array_pkg.sv | 25 ++
 rtl/sys_array_mac_ctrl_if.sv | 39 +++
 rtl/sys_array_mac_ctrl.sv | 115 +++++++++++
 tb/tb_sys_array_mac_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array MAC sequencer slice.
package sys_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_CAPTURE,
    ST_CHECK
  } mac_state_e;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_VEC_LEN      = 4;
  localparam int DEF_CELL_LATENCY = 1;

  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Counters need at least one bit even when only a single value is ever used.
  function automatic int idx_width(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/sys_array_mac_ctrl_if.sv
// Bundle between the MAC sequencer (master), preset storage, start/abort control and the array cell.
interface sys_array_mac_ctrl_if #(
  parameter int DATA_WIDTH = sys_array_pkg::DEF_DATA_WIDTH,
  parameter int VEC_LEN    = sys_array_pkg::DEF_VEC_LEN
);
  import sys_array_pkg::*;

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam int IDX_W = idx_width(VEC_LEN);

  logic                  start;
  logic                  abort;
  logic [IDX_W-1:0]      rom_addr;
  logic [DATA_WIDTH-1:0] rom_par;
  logic [DATA_WIDTH-1:0] rom_inp;
  logic [ACC_W-1:0]      rom_expected;
  logic                  cell_param_load;
  logic [DATA_WIDTH-1:0] cell_param_data;
  logic [DATA_WIDTH-1:0] cell_input_data;
  logic [ACC_W-1:0]      cell_prop_data;
  logic [ACC_W-1:0]      cell_out_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ACC_W-1:0]      result;

  modport master (
    input  start, abort, rom_par, rom_inp, rom_expected, cell_out_data,
    output rom_addr, cell_param_load, cell_param_data, cell_input_data, cell_prop_data,
           busy, done, pass, result
  );

  modport slave (
    output start, abort, rom_par, rom_inp, rom_expected, cell_out_data,
    input  rom_addr, cell_param_load, cell_param_data, cell_input_data, cell_prop_data,
           busy, done, pass, result
  );

endinterface

// File: rtl/sys_array_mac_ctrl.sv
// Sequencer that reuses one systolic-array cell as a dot-product engine and
// checks the finished sum against the preset's expected value.
module sys_array_mac_ctrl
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VEC_LEN      = DEF_VEC_LEN,
  parameter int CELL_LATENCY = DEF_CELL_LATENCY
) (
  input logic                 clk,
  input logic                 reset,
  sys_array_mac_ctrl_if.master bus
);

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam int IDX_W = idx_width(VEC_LEN);
  localparam int LAT_W = idx_width(CELL_LATENCY);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
  localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(CELL_LATENCY - 1);

  mac_state_e       state;
  mac_state_e       state_next;
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] wait_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] result_q;
  logic             pass_q;
  logic             done_q;
  logic             start_ok;

  assign start_ok = bus.start && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      result_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      if (state != ST_IDLE && bus.abort) begin
        idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              idx <= '0;
              acc <= '0;
            end
          end
          ST_LOAD: wait_cnt <= '0;
          ST_FEED: wait_cnt <= wait_cnt + 1'b1;
          ST_CAPTURE: begin
            // The cell output already holds prop + inp*weight, so it becomes the new running sum.
            acc <= bus.cell_out_data;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
          ST_CHECK: begin
            result_q <= acc;
            pass_q   <= (acc == bus.rom_expected);
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    if (state != ST_IDLE && bus.abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_ok) state_next = ST_LOAD;
        ST_LOAD:    state_next = ST_FEED;
        ST_FEED:    if (wait_cnt == LAST_WAIT) state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = (idx == LAST_IDX) ? ST_CHECK : ST_LOAD;
        ST_CHECK:   state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Operands stay on the cell through FEED and CAPTURE so a deep cell pipe sees stable inputs.
  always_comb begin
    bus.cell_param_load = 1'b0;
    bus.cell_param_data = '0;
    bus.cell_input_data = '0;
    bus.cell_prop_data  = '0;
    case (state)
      ST_LOAD: begin
        bus.cell_param_load = 1'b1;
        bus.cell_param_data = bus.rom_par;
      end
      ST_FEED, ST_CAPTURE: begin
        bus.cell_input_data = bus.rom_inp;
        bus.cell_prop_data  = acc;
      end
      default: ;
    endcase
  end

  assign bus.rom_addr = idx;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_sys_array_mac_ctrl.sv
// Self-checking bench for sys_array_mac_ctrl: dot-product/timing model plus behavioural cells
// with 1- and 3-cycle latency.
module tb_sys_array_mac_ctrl;
  import sys_array_pkg::*;

  localparam int DW   = 8;
  localparam int VL   = 4;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int AW   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sys_array_mac_ctrl_if #(.DATA_WIDTH(DW), .VEC_LEN(VL)) bus ();
  sys_array_mac_ctrl_if #(.DATA_WIDTH(DW), .VEC_LEN(VL)) bus3 ();

  sys_array_mac_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL), .CELL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  sys_array_mac_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL), .CELL_LATENCY(LAT3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  logic [DW-1:0] par_mem [VL];
  logic [DW-1:0] inp_mem [VL];
  logic [AW-1:0] expected_val;

  assign bus.rom_par       = par_mem[bus.rom_addr];
  assign bus.rom_inp       = inp_mem[bus.rom_addr];
  assign bus.rom_expected  = expected_val;
  assign bus3.rom_par      = par_mem[bus3.rom_addr];
  assign bus3.rom_inp      = inp_mem[bus3.rom_addr];
  assign bus3.rom_expected = expected_val;
  assign bus3.abort        = 1'b0;

  // Behavioural cells: weight register plus an N-deep pipe on prop + inp*weight.
  logic [DW-1:0] preg, preg3;
  logic [AW-1:0] pipe1;
  logic [AW-1:0] pipe3 [LAT3];
  always @(posedge clk) begin
    if (bus.cell_param_load) preg <= bus.cell_param_data;
    pipe1 <= bus.cell_prop_data + AW'(bus.cell_input_data) * AW'(preg);
    if (bus3.cell_param_load) preg3 <= bus3.cell_param_data;
    pipe3[0] <= bus3.cell_prop_data + AW'(bus3.cell_input_data) * AW'(preg3);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign bus.cell_out_data  = pipe1;
  assign bus3.cell_out_data = pipe3[LAT3-1];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [AW-1:0] dot_ref();
    int s = 0;
    for (int k = 0; k < VL; k++) s += int'(par_mem[k]) * int'(inp_mem[k]);
    return AW'(s);
  endfunction

  function automatic int run_len(input int lat);
    return VL * (lat + 2) + 1;
  endfunction

  // Model: a run started at edge 0 completes at edge run_len; abort/reset cancel it.
  int            cyc = 0;
  int            m_t = 0;
  int            m_start_cyc = 0;
  int            m_loads = 0;
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  bit            m_pass = 1'b0;
  logic [AW-1:0] m_result = '0;
  int            start3_cyc = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_done <= 1'b0;
    if (bus3.start) start3_cyc <= cyc + 1;
    if (reset) begin
      m_active <= 1'b0;
      m_result <= '0;
      m_pass   <= 1'b0;
    end else if (!m_active) begin
      if (bus.start && !bus.abort) begin
        m_active    <= 1'b1;
        m_t         <= 0;
        m_loads     <= 0;
        m_start_cyc <= cyc + 1;
      end
    end else if (bus.abort) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (bus.cell_param_load) m_loads <= m_loads + 1;
      if (m_t + 1 == run_len(LAT)) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_result <= dot_ref();
        m_pass   <= (dot_ref() == expected_val);
      end
    end
  end

  bit chk_en = 1'b0;
  int done_cnt = 0;
  int last_done_lat = 0;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      checkOutput("busy", 32'(bus.busy), 32'(m_active));
      checkOutput("done", 32'(bus.done), 32'(m_done));
      checkOutput("result", 32'(bus.result), 32'(m_result));
      checkOutput("pass", 32'(bus.pass), 32'(m_pass));
      if (m_done) checkOutput("param_load_count", 32'(m_loads), 32'(VL));
      if (bus.done) begin
        done_cnt++;
        last_done_lat = cyc - m_start_cyc;
      end
    end
  end

  // Deep-latency cell: every operand window must hold steady for exactly LAT3+1 cycles.
  int            win_len = 0;
  logic [DW-1:0] win_inp;
  logic [AW-1:0] win_prop;
  int            done3_lat = 0;
  bit            done3_seen = 1'b0;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (bus3.done) begin
        done3_seen = 1'b1;
        done3_lat  = cyc - start3_cyc;
      end
      if (bus3.cell_input_data != '0 && !bus3.cell_param_load) begin
        if (win_len == 0) begin
          win_inp  = bus3.cell_input_data;
          win_prop = bus3.cell_prop_data;
        end else begin
          checkOutput("hold_input", 32'(bus3.cell_input_data), 32'(win_inp));
          checkOutput("hold_prop", 32'(bus3.cell_prop_data), 32'(win_prop));
        end
        win_len++;
      end else if (win_len != 0) begin
        checkOutput("window_len", 32'(win_len), 32'(LAT3 + 1));
        win_len = 0;
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit a, input bit r);
    bus.start  = s;
    bus.abort  = a;
    reset      = r;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(bus.pass), 32'd0);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'd0);
    checkOutput({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    checkOutput({tag, "_param_load"}, 32'(bus.cell_param_load), 32'd0);
    checkOutput({tag, "_param_data"}, 32'(bus.cell_param_data), 32'd0);
    checkOutput({tag, "_input_data"}, 32'(bus.cell_input_data), 32'd0);
    checkOutput({tag, "_prop_data"}, 32'(bus.cell_prop_data), 32'd0);
  endtask

  task automatic loadVector(input logic [DW-1:0] p0, p1, p2, p3, i0, i1, i2, i3, input logic [AW-1:0] e);
    par_mem[0] = p0; par_mem[1] = p1; par_mem[2] = p2; par_mem[3] = p3;
    inp_mem[0] = i0; inp_mem[1] = i1; inp_mem[2] = i2; inp_mem[3] = i3;
    expected_val = e;
  endtask

  initial begin
    int dc;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus3.start = 1'b0;
    loadVector(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 16'd70);
    idle(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    idle(1);
    checkResetState("reset");

    $display("[TB] basic dot product, expected matches");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(30, "run1");
    checkOutput("run1_result", 32'(bus.result), 32'h0046);
    checkOutput("run1_pass", 32'(bus.pass), 32'd1);
    checkOutput("run1_latency", 32'(last_done_lat), 32'd13);
    idle(2);

    $display("[TB] same data, expected mismatches");
    expected_val = 16'd71;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(30, "run2");
    checkOutput("run2_result", 32'(bus.result), 32'h0046);
    checkOutput("run2_pass", 32'(bus.pass), 32'd0);
    checkOutput("run2_latency", 32'(last_done_lat), 32'd13);
    idle(2);

    $display("[TB] all-ones operands wrap the accumulator");
    loadVector(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hF804);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(30, "run3");
    checkOutput("run3_result", 32'(bus.result), 32'hF804);
    checkOutput("run3_pass", 32'(bus.pass), 32'd1);
    idle(2);

    $display("[TB] start pulses during a run are ignored");
    loadVector(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 16'd70);
    dc = done_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(30, "run4");
    checkOutput("run4_latency", 32'(last_done_lat), 32'd13);
    idle(20);
    checkOutput("run4_done_count", 32'(done_cnt - dc), 32'd1);

    $display("[TB] abort mid-run");
    dc = done_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_prop", 32'(bus.cell_prop_data), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'h0046);
    checkOutput("abort_pass", 32'(bus.pass), 32'd1);
    idle(20);
    checkOutput("abort_done_count", 32'(done_cnt - dc), 32'd0);

    $display("[TB] start and abort together in idle");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("start_abort_busy", 32'(bus.busy), 32'd0);

    $display("[TB] reset mid-run, then fresh run");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkResetState("midreset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(30, "run5");
    checkOutput("run5_result", 32'(bus.result), 32'h0046);
    checkOutput("run5_pass", 32'(bus.pass), 32'd1);
    idle(2);

    $display("[TB] three-cycle cell latency");
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    for (int i = 0; i < 60 && !done3_seen; i++) @(negedge clk);
    if (!done3_seen) checkOutput("lat3_timeout", 32'd0, 32'd1);
    checkOutput("lat3_latency", 32'(done3_lat), 32'd21);
    checkOutput("lat3_result", 32'(bus3.result), 32'h0046);
    checkOutput("lat3_pass", 32'(bus3.pass), 32'd1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
